// File: rtl/common_chars_pkg.sv
// Shared definitions for the common-characters extraction stage:
// memory geometry defaults, null terminator and FSM state encoding.
package common_chars_pkg;

    localparam int CHAR_AW_DEF = 14;
    localparam int IDX_AW_DEF  = 8;
    localparam int LEN_W_DEF   = 8;

    localparam logic [7:0] NULL_CHAR = 8'h00;

    localparam logic [3:0] ST_IDLE     = 4'd0;
    localparam logic [3:0] ST_IDX_A    = 4'd1;
    localparam logic [3:0] ST_IDX_B    = 4'd2;
    localparam logic [3:0] ST_IDX_WAIT = 4'd3;
    localparam logic [3:0] ST_RD_A     = 4'd4;
    localparam logic [3:0] ST_RD_B     = 4'd5;
    localparam logic [3:0] ST_CMP      = 4'd6;
    localparam logic [3:0] ST_EMIT     = 4'd7;
    localparam logic [3:0] ST_DONE     = 4'd8;

    typedef enum logic [3:0] {
        S_IDLE     = ST_IDLE,
        S_IDX_A    = ST_IDX_A,
        S_IDX_B    = ST_IDX_B,
        S_IDX_WAIT = ST_IDX_WAIT,
        S_RD_A     = ST_RD_A,
        S_RD_B     = ST_RD_B,
        S_CMP      = ST_CMP,
        S_EMIT     = ST_EMIT,
        S_DONE     = ST_DONE
    } state_e;

endpackage

// File: rtl/common_chars.sv
// Walks two null-terminated words in character memory and streams out the
// characters that agree position-by-position (valid/ready byte stream).
//
// state    | meaning
// IDLE     | ready for a request, latches word indices
// IDX_A    | index memory read of word A start address
// IDX_B    | index memory read of word B, capture A start
// IDX_WAIT | capture B start address
// RD_A     | character read at aptr
// RD_B     | character read at bptr, capture char A
// CMP      | compare char A with char B (on read data)
// EMIT     | present matching byte until accepted
// DONE     | results held until request drops
module common_chars
    import common_chars_pkg::*;
#(
    parameter int CHAR_AW = CHAR_AW_DEF,
    parameter int IDX_AW  = IDX_AW_DEF,
    parameter int LEN_W   = LEN_W_DEF
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               vld_i,
    input  logic [IDX_AW-1:0]  a_idx_i,
    input  logic [IDX_AW-1:0]  b_idx_i,
    output logic [IDX_AW-1:0]  idx_raddr_o,
    input  logic [CHAR_AW-1:0] idx_rdat_i,
    output logic [CHAR_AW-1:0] char_raddr_o,
    input  logic [7:0]         char_rdat_i,
    output logic               out_vld_o,
    output logic [7:0]         out_dat_o,
    input  logic               out_rdy_i,
    output logic               rdy_o,
    output logic               done_o,
    output logic [LEN_W-1:0]   len_o,
    output logic [1:0]         mism_o
);

    state_e             state_q, state_d;
    logic [IDX_AW-1:0]  a_idx_q, a_idx_d;
    logic [IDX_AW-1:0]  b_idx_q, b_idx_d;
    logic [CHAR_AW-1:0] aptr_q, aptr_d;
    logic [CHAR_AW-1:0] bptr_q, bptr_d;
    logic [7:0]         tmp_q, tmp_d;
    logic [7:0]         out_dat_q, out_dat_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [1:0]         mism_q, mism_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            a_idx_q   <= '0;
            b_idx_q   <= '0;
            aptr_q    <= '0;
            bptr_q    <= '0;
            tmp_q     <= '0;
            out_dat_q <= '0;
            len_q     <= '0;
            mism_q    <= '0;
        end else begin
            state_q   <= state_d;
            a_idx_q   <= a_idx_d;
            b_idx_q   <= b_idx_d;
            aptr_q    <= aptr_d;
            bptr_q    <= bptr_d;
            tmp_q     <= tmp_d;
            out_dat_q <= out_dat_d;
            len_q     <= len_d;
            mism_q    <= mism_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        a_idx_d      = a_idx_q;
        b_idx_d      = b_idx_q;
        aptr_d       = aptr_q;
        bptr_d       = bptr_q;
        tmp_d        = tmp_q;
        out_dat_d    = out_dat_q;
        len_d        = len_q;
        mism_d       = mism_q;
        idx_raddr_o  = '0;
        char_raddr_o = '0;

        case (state_q)
            S_IDLE: begin
                if (vld_i) begin
                    a_idx_d = a_idx_i;
                    b_idx_d = b_idx_i;
                    len_d   = '0;
                    mism_d  = '0;
                    state_d = S_IDX_A;
                end
            end
            S_IDX_A: begin
                idx_raddr_o = a_idx_q;
                state_d     = S_IDX_B;
            end
            S_IDX_B: begin
                idx_raddr_o = b_idx_q;
                aptr_d      = idx_rdat_i;
                state_d     = S_IDX_WAIT;
            end
            S_IDX_WAIT: begin
                bptr_d  = idx_rdat_i;
                state_d = S_RD_A;
            end
            S_RD_A: begin
                char_raddr_o = aptr_q;
                aptr_d       = aptr_q + CHAR_AW'(1);
                state_d      = S_RD_B;
            end
            S_RD_B: begin
                char_raddr_o = bptr_q;
                tmp_d        = char_rdat_i;
                bptr_d       = bptr_q + CHAR_AW'(1);
                state_d      = S_CMP;
            end
            S_CMP: begin
                // A null on either side ends the walk without counting a mismatch
                if (tmp_q == NULL_CHAR || char_rdat_i == NULL_CHAR) begin
                    state_d = S_DONE;
                end else if (tmp_q == char_rdat_i) begin
                    out_dat_d = tmp_q;
                    state_d   = S_EMIT;
                end else begin
                    if (mism_q != 2'b11) mism_d = mism_q + 2'd1;
                    state_d = S_RD_A;
                end
            end
            S_EMIT: begin
                if (out_rdy_i) begin
                    if (len_q != '1) len_d = len_q + LEN_W'(1);
                    state_d = S_RD_A;
                end
            end
            S_DONE: begin
                if (!vld_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign out_vld_o = (state_q == S_EMIT);
    assign out_dat_o = out_dat_q;
    assign rdy_o     = (state_q == S_IDLE);
    assign done_o    = (state_q == S_DONE);
    assign len_o     = len_q;
    assign mism_o    = mism_q;

endmodule

// File: tb/tb_common_chars.sv
// Directed bench for common_chars: table of word pairs with expected streams,
// plus hand sequences for stalls, mid-emit reset, length saturation and wrap.
module tb_common_chars;

    localparam int CHAR_AW = 14;
    localparam int IDX_AW  = 8;
    localparam int LEN_W   = 8;
    localparam int MEM_SZ  = 1 << CHAR_AW;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               vld;
    logic [IDX_AW-1:0]  a_idx, b_idx;
    logic [IDX_AW-1:0]  idx_raddr;
    logic [CHAR_AW-1:0] idx_rdat;
    logic [CHAR_AW-1:0] char_raddr;
    logic [7:0]         char_rdat;
    logic               out_vld;
    logic [7:0]         out_dat;
    logic               out_rdy;
    logic               rdy, done;
    logic [LEN_W-1:0]   len;
    logic [1:0]         mism;

    logic [CHAR_AW-1:0] idx_mem [0:(1<<IDX_AW)-1];
    logic [7:0]         char_mem [0:MEM_SZ-1];

    byte unsigned       got[$];
    int                 trace[$];

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    common_chars #(.CHAR_AW(CHAR_AW), .IDX_AW(IDX_AW), .LEN_W(LEN_W)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .vld_i        (vld),
        .a_idx_i      (a_idx),
        .b_idx_i      (b_idx),
        .idx_raddr_o  (idx_raddr),
        .idx_rdat_i   (idx_rdat),
        .char_raddr_o (char_raddr),
        .char_rdat_i  (char_rdat),
        .out_vld_o    (out_vld),
        .out_dat_o    (out_dat),
        .out_rdy_i    (out_rdy),
        .rdy_o        (rdy),
        .done_o       (done),
        .len_o        (len),
        .mism_o       (mism)
    );

    always @(posedge clk) begin
        idx_rdat  <= idx_mem[idx_raddr];
        char_rdat <= char_mem[char_raddr];
    end

    always @(posedge clk) begin
        if (rst_n && out_vld && out_rdy) got.push_back(out_dat);
        trace.push_back(int'(char_raddr));
    end

    typedef struct {
        string wa;
        int    adra;
        string wb;
        int    adrb;
        string exp;
        int    exp_len;
        int    exp_mism;
        int    exp_first;
        int    exp_done;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic load_word(input string s, input int adr);
        for (int k = 0; k < s.len(); k++) char_mem[(adr + k) % MEM_SZ] = s[k];
        char_mem[(adr + s.len()) % MEM_SZ] = 8'h00;
    endtask

    task automatic check_stream(input string name, input string exp);
        check({name, "_nbytes"}, got.size(), exp.len());
        for (int k = 0; k < exp.len() && k < got.size(); k++)
            check($sformatf("%s_byte%0d", name, k), int'(got[k]), int'(exp[k]));
    endtask

    // One request: edges are numbered so that edge N samples vld_i in IDLE
    task automatic run(input string wa, input int adra, input string wb, input int adrb,
                       input int stall, output int first_edge, output int done_edge);
        int     j;
        int     held;
        logic [7:0] held_dat;
        load_word(wa, adra);
        load_word(wb, adrb);
        idx_mem[0] = CHAR_AW'(adra);
        idx_mem[1] = CHAR_AW'(adrb);
        got.delete();
        trace.delete();
        first_edge = -1;
        done_edge  = -1;
        held       = 0;
        held_dat   = 8'h00;
        @(negedge clk);
        out_rdy = (stall == 0);
        a_idx   = 8'd0;
        b_idx   = 8'd1;
        vld     = 1'b1;
        @(posedge clk);
        j = 0;
        while (done_edge < 0 && j < 5000) begin
            #1;
            if (out_vld && first_edge < 0) first_edge = j + 1;
            if (out_vld && stall > 0 && held <= stall) begin
                if (held == 0) held_dat = out_dat;
                else begin
                    check("stall_vld_hold", int'(out_vld), 1);
                    check("stall_dat_hold", int'(out_dat), int'(held_dat));
                    check("stall_no_xfer", got.size(), 0);
                end
                held++;
                if (held > stall) out_rdy = 1'b1;
            end
            if (done) done_edge = j + 1;
            @(posedge clk);
            j++;
        end
        if (done_edge < 0) check("done_timeout", 0, 1);
    endtask

    task automatic release_req();
        @(negedge clk);
        vld = 1'b0;
        @(posedge clk);
        #1;
        check("back_to_idle_rdy", int'(rdy), 1);
        check("back_to_idle_done", int'(done), 0);
    endtask

    initial begin
        int    fe, de, p;
        string big;
        int    wexp[3];

        vecs[0] = '{"abcde",  0,  "axcye",  6,  "ace",  3, 2,  7, -1};
        vecs[1] = '{"fghij",  0,  "fguij",  6,  "fgij", 4, 1, -1, -1};
        vecs[2] = '{"abc",    0,  "ab",     6,  "ab",   2, 0, -1, 15};
        vecs[3] = '{"",       0,  "xyz",    6,  "",     0, 0, -1,  7};
        vecs[4] = '{"abcdef", 0,  "uvwxyz", 20, "",     0, 3, -1, 25};
        vecs[5] = '{"same",   40, "same",   60, "same", 4, 0,  7, -1};

        for (int k = 0; k < MEM_SZ; k++) char_mem[k] = 8'h00;
        for (int k = 0; k < (1 << IDX_AW); k++) idx_mem[k] = '0;
        rst_n   = 1'b0;
        vld     = 1'b0;
        a_idx   = '0;
        b_idx   = '0;
        out_rdy = 1'b1;

        #12;
        check("rst_rdy", int'(rdy), 1);
        check("rst_done", int'(done), 0);
        check("rst_out_vld", int'(out_vld), 0);
        check("rst_out_dat", int'(out_dat), 0);
        check("rst_len", int'(len), 0);
        check("rst_mism", int'(mism), 0);
        check("rst_idx_raddr", int'(idx_raddr), 0);
        check("rst_char_raddr", int'(char_raddr), 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int v = 0; v < 6; v++) begin
            run(vecs[v].wa, vecs[v].adra, vecs[v].wb, vecs[v].adrb, 0, fe, de);
            check_stream($sformatf("v%0d_stream", v), vecs[v].exp);
            check($sformatf("v%0d_len", v), int'(len), vecs[v].exp_len);
            check($sformatf("v%0d_mism", v), int'(mism), vecs[v].exp_mism);
            if (vecs[v].exp_first >= 0) check($sformatf("v%0d_first_vld_edge", v), fe, vecs[v].exp_first);
            if (vecs[v].exp_done >= 0) check($sformatf("v%0d_done_edge", v), de, vecs[v].exp_done);
            release_req();
        end

        // Consumer stalls for 5 cycles on the first byte
        run("fghij", 0, "fguij", 6, 5, fe, de);
        check_stream("stall_stream", "fgij");
        check("stall_len", int'(len), 4);
        check("stall_mism", int'(mism), 1);
        release_req();

        // Reset asserted while the second byte is being offered
        load_word("fghij", 0);
        load_word("fguij", 6);
        idx_mem[0] = 14'd0;
        idx_mem[1] = 14'd6;
        got.delete();
        @(negedge clk);
        out_rdy = 1'b1;
        vld     = 1'b1;
        for (int j = 0; j < 200 && !(got.size() >= 1 && out_vld); j++) begin
            @(posedge clk);
            #1;
        end
        check("rst_mid_emit_reached", int'(out_vld), 1);
        check("rst_mid_emit_dat", int'(out_dat), int'(8'h67));
        rst_n = 1'b0;
        vld   = 1'b0;
        #1;
        check("rst_mid_out_vld", int'(out_vld), 0);
        check("rst_mid_rdy", int'(rdy), 1);
        check("rst_mid_len", int'(len), 0);
        @(negedge clk);
        rst_n = 1'b1;
        run("fghij", 0, "fguij", 6, 0, fe, de);
        check_stream("rerun_stream", "fgij");
        check("rerun_len", int'(len), 4);
        check("rerun_mism", int'(mism), 1);
        release_req();

        // Length counter saturates while bytes keep flowing
        big = "";
        for (int k = 0; k < 260; k++) big = {big, "k"};
        run(big, 1000, big, 2000, 0, fe, de);
        check("sat_nbytes", got.size(), 260);
        check("sat_len", int'(len), 255);
        check("sat_mism", int'(mism), 0);
        release_req();

        // Word A straddles the top of character memory
        run("pqr", 16382, "pqr", 100, 0, fe, de);
        check_stream("wrap_stream", "pqr");
        wexp[0] = 16382;
        wexp[1] = 16383;
        wexp[2] = 0;
        p = 0;
        for (int k = 0; k < trace.size(); k++)
            if (p < 3 && trace[k] == wexp[p]) p++;
        check("wrap_addr_order", p, 3);
        release_req();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/common_chars.md
# common_chars

Downstream stage of the pair-search FSM. Once the search reports a near-matching word pair as word indices, this block fetches both start addresses from the index memory and walks the two null-terminated strings in character memory. It emits the characters that agree position-by-position as a byte stream with a valid/ready handshake. The output is the puzzle answer string.

## Interface
Parameters:
- CHAR_AW, 14, character memory address width (also index memory data width)
- IDX_AW, 8, index memory address width / word-index width
- LEN_W, 8, width of emitted-length counter

Ports:
- clk_i  in  1  clock, rising edge
- rst_ni  in  1  reset, asynchronous, active-low
- vld_i  in  1  request; sampled in IDLE; must stay high until done_o
- a_idx_i  in  IDX_AW  first word index
- b_idx_i  in  IDX_AW  second word index
- idx_raddr_o  out  IDX_AW  index memory read address (1-cycle synchronous read)
- idx_rdat_i  in  CHAR_AW  index memory read data (word start address)
- char_raddr_o  out  CHAR_AW  character memory read address (1-cycle synchronous read)
- char_rdat_i  in  8  character memory read data
- out_vld_o  out  1  output byte valid
- out_dat_o  out  8  output byte
- out_rdy_i  in  1  consumer ready
- rdy_o  out  1  high in IDLE
- done_o  out  1  high in DONE
- len_o  out  LEN_W  bytes emitted, valid while done_o
- mism_o  out  2  positions that differed, saturating at 3

## Operation
- States: IDLE, IDX_A, IDX_B, IDX_WAIT, RD_A, RD_B, CMP, EMIT, DONE.
- IDLE: rdy_o=1. When vld_i is high, latch a_idx_i/b_idx_i, clear len and mism, then go to IDX_A.
- IDX_A: idx_raddr_o=a_idx. Next state IDX_B.
- IDX_B: idx_raddr_o=b_idx; aptr<=idx_rdat_i. Next state IDX_WAIT.
- IDX_WAIT: bptr<=idx_rdat_i. Next state RD_A.
- RD_A: char_raddr_o=aptr; aptr<=aptr+1. Next state RD_B.
- RD_B: char_raddr_o=bptr; tmp<=char_rdat_i (char A); bptr<=bptr+1. Next state CMP.
- CMP: char_rdat_i is char B.
  - If tmp==0 or B==0, go to DONE; no emit and no mismatch count.
  - Else if tmp==B: out_dat<=tmp; go to EMIT.
  - Else: mism<=sat(mism+1); go to RD_A.
- EMIT: out_vld_o=1, out_dat_o stable. On out_rdy_i: len<=sat(len+1); go to RD_A. Otherwise hold.
- DONE: done_o=1; len_o and mism_o hold. When vld_i drops, go to IDLE.
- Address outputs are 0 outside their driving states.
- aptr/bptr wrap modulo 2^CHAR_AW.
- Unequal-length words: the walk stops at the first null on either side.
- len saturates at 2^LEN_W-1; further emits still occur.
- rst_ni low at any time, including mid-EMIT: asynchronously return to IDLE; discard the pending byte.

## Timing
- Reset values: state IDLE, rdy_o=1, done_o=0, out_vld_o=0, out_dat_o=0, len_o=0, mism_o=0, idx_raddr_o=0, char_raddr_o=0, pointers and tmp 0.
- Edge N samples vld_i in IDLE. RD_A is the state at edge N+4. The first CMP is at edge N+6.
- Per position with out_rdy_i held high:
  - 3 cycles when mismatched (RD_A, RD_B, CMP).
  - 4 cycles when matched (adds EMIT).
- Terminating null: DONE one edge after that CMP.
- out_vld_o is registered (state decode). Once raised, it holds with constant out_dat_o until accepted. Transfer = out_vld_o & out_rdy_i at the rising edge.
- If vld_i is already low in DONE, the block returns to IDLE the next edge. A new request can be accepted no earlier than the following edge.

## Structure
- Shared package holds:
  - the state encoding localparams
  - CHAR_AW/IDX_AW defaults, matching the memory instances used by the pair search
  - the null character constant (8'h00)
- Single module; no sub-module needed.
- It shares the character memory read port with the diff stage through the top-level mux, selected by the pair-search done signal.

## Test plan
- Words "abcde" at 0 and "axcye" at 6 (idx[0]=0, idx[1]=6); a=0, b=1, out_rdy_i=1 -> bytes 'a','c','e'; len_o=3; mism_o=2; first out_vld_o at edge N+7.
- "fghij" at 0, "fguij" at 6 -> "fgij"; len_o=4; mism_o=1.
- Same as scenario 2 with out_rdy_i low for 5 cycles at the first EMIT -> out_dat_o='f' held stable, no duplicate, final stream unchanged.
- "abc" vs "ab" -> "ab"; len_o=2; mism_o=0. Empty word (null at start) vs "xyz" -> no bytes; DONE at edge N+7.
- rst_ni pulsed low during the second EMIT -> out_vld_o=0 and rdy_o=1 immediately. A rerun then yields the full correct stream.
- Word starting at 16382 of length 3 -> addresses 16382, 16383, 0 read in order (wrap).
